// File: rtl/seq_mult_param.sv
// Sequential shift-and-add multiplier with an X:A:B accumulator, unsigned or
// two's-complement mode, fixed latency of 2*WIDTH+1 cycles from start to Done.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST  = CW'(WIDTH - 1);
  localparam logic [CW-1:0] ITERS = CW'(WIDTH);

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, HOLD} state_t;

  state_t                 state;
  logic signed [WIDTH-1:0] a;
  logic signed [WIDTH-1:0] b;
  logic                   x;
  logic [CW-1:0]          count;
  logic                   mode;
  logic                   run_q;
  logic                   run_rise;
  logic [WIDTH:0]         sum;
  logic [CW-1:0]          count_nx;

  // Partial-product step; the top partial product is negative in signed mode,
  // so the last iteration subtracts instead of adding.
  function automatic logic [WIDTH:0] add_step(input logic [WIDTH-1:0] acc,
                                              input logic [WIDTH-1:0] op,
                                              input logic             sgn,
                                              input logic             sub);
    logic [WIDTH:0] ea;
    logic [WIDTH:0] es;
    ea = {sgn & acc[WIDTH-1], acc};
    es = {sgn & op[WIDTH-1], op};
    return sub ? (ea - es) : (ea + es);
  endfunction

  assign run_rise = Run & ~run_q;
  assign sum      = add_step(a, S, mode, mode && (count == LAST));
  assign count_nx = count + CW'(1);

  assign Aval = a;
  assign Bval = b;
  assign X    = x;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      a     <= '0;
      b     <= '0;
      x     <= 1'b0;
      count <= '0;
      mode  <= 1'b0;
      run_q <= 1'b0;
      Busy  <= 1'b0;
      Done  <= 1'b0;
    end else begin
      run_q <= Run;
      Done  <= 1'b0;
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            x <= 1'b0;
            a <= '0;
            b <= S;
          end else if (run_rise) begin
            mode  <= Signed_Mode;
            Busy  <= 1'b1;
            state <= CLR;
          end
        end
        CLR: begin
          x     <= 1'b0;
          a     <= '0;
          count <= '0;
          state <= ADD;
        end
        ADD: begin
          if (b[0]) begin
            a <= sum[WIDTH-1:0];
            x <= sum[WIDTH];
          end
          state <= SHIFT;
        end
        SHIFT: begin
          x     <= mode & x;
          a     <= {x, a[WIDTH-1:1]};
          b     <= {a[0], b[WIDTH-1:1]};
          count <= count_nx;
          if (count_nx < ITERS) begin
            state <= ADD;
          end else begin
            Busy  <= 1'b0;
            Done  <= 1'b1;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (!Run) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_param.sv
// Bench for seq_mult_param: table of 8-bit multiplies through a scoreboard,
// plus hand sequences for chaining, 4-bit latency/hold, reset abort and priority.
module tb_seq_mult_param;

  logic       clk;
  logic       rst_n;
  logic       run, clr_ld, sm;
  logic [7:0] s;
  logic [7:0] aval, bval;
  logic       x, busy, done;
  logic       run4, clr4, sm4;
  logic [3:0] s4;
  logic [3:0] a4, b4;
  logic       x4, busy4, done4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sgn;
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ex;
  } vec_t;

  typedef struct {
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ex;
  } exp_t;

  vec_t vecs[9];
  exp_t sb[$];

  seq_mult_param #(.WIDTH(8)) u8 (
    .Clk(clk), .Reset(rst_n), .Run(run), .ClearA_LoadB(clr_ld),
    .Signed_Mode(sm), .S(s), .Aval(aval), .Bval(bval), .X(x),
    .Busy(busy), .Done(done)
  );

  seq_mult_param #(.WIDTH(4)) u4 (
    .Clk(clk), .Reset(rst_n), .Run(run4), .ClearA_LoadB(clr4),
    .Signed_Mode(sm4), .S(s4), .Aval(a4), .Bval(b4), .X(x4),
    .Busy(busy4), .Done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic load_b(input logic [7:0] bv);
    @(negedge clk);
    s      = bv;
    clr_ld = 1'b1;
    @(negedge clk);
    clr_ld = 1'b0;
    check("load_b", {24'd0, bval}, {24'd0, bv});
  endtask

  // Press Run, wait for Done, compare against the oldest scoreboard entry.
  task automatic run_mult(input logic sgn, input logic [7:0] sv, input string nm);
    int   k;
    exp_t e;
    @(negedge clk);
    sm  = sgn;
    s   = sv;
    run = 1'b1;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done) break;
    end
    check({nm, "_latency"}, k, 18);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard actual=empty required=entry", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_A"}, {24'd0, aval}, {24'd0, e.ea});
      check({nm, "_B"}, {24'd0, bval}, {24'd0, e.eb});
      check({nm, "_X"}, {31'd0, x}, {31'd0, e.ex});
    end
    @(posedge clk);
    #1;
    check({nm, "_done_pulse"}, {31'd0, done}, 32'd0);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    @(posedge clk);
  endtask

  initial begin
    int k;
    int bc;
    int dc;
    vecs[0] = '{1'b1, 8'h07, 8'hFE, 8'hFF, 8'hF2, 1'b1};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0};
    vecs[3] = '{1'b0, 8'h0C, 8'h0A, 8'h00, 8'h78, 1'b0};
    vecs[4] = '{1'b1, 8'h7F, 8'h80, 8'hC0, 8'h80, 1'b1};
    vecs[5] = '{1'b1, 8'h00, 8'h55, 8'h00, 8'h00, 1'b0};
    vecs[6] = '{1'b0, 8'h80, 8'h02, 8'h01, 8'h00, 1'b0};
    vecs[7] = '{1'b1, 8'hFF, 8'hFF, 8'h00, 8'h01, 1'b0};
    vecs[8] = '{1'b1, 8'h05, 8'h03, 8'h00, 8'h0F, 1'b0};

    rst_n = 1'b0;
    run = 1'b0; clr_ld = 1'b0; sm = 1'b0; s = 8'h00;
    run4 = 1'b0; clr4 = 1'b0; sm4 = 1'b0; s4 = 4'h0;
    #1;
    check("reset_outputs", {13'd0, aval, bval, x, busy, done}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_hold", {13'd0, aval, bval, x, busy, done}, 32'd0);

    // Table-driven multiplies.
    for (int i = 0; i < 9; i++) begin
      load_b(vecs[i].b);
      sb.push_back('{vecs[i].ea, vecs[i].eb, vecs[i].ex});
      run_mult(vecs[i].sgn, vecs[i].s, $sformatf("vec%0d", i));
    end

    // Chained run: B keeps the previous low half (-14), times -2 = 28.
    load_b(8'h07);
    sb.push_back('{8'hFF, 8'hF2, 1'b1});
    run_mult(1'b1, 8'hFE, "chain_first");
    sb.push_back('{8'h00, 8'h1C, 1'b0});
    run_mult(1'b1, 8'hFE, "chain_second");

    // WIDTH=4: latency, Busy span, long HOLD, ignored load during HOLD.
    @(negedge clk);
    s4 = 4'h3; clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0; sm4 = 1'b0; s4 = 4'h5; run4 = 1'b1;
    bc = 0;
    for (k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (busy4) bc++;
      if (done4) break;
    end
    check("w4_latency", k, 10);
    check("w4_busy_cycles", bc, 9);
    check("w4_product", {24'd0, a4, b4}, 32'h0F);
    dc = 0;
    bc = 0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk);
      #1;
      if (done4) dc++;
      if (busy4) bc++;
    end
    check("w4_no_second_done", dc, 0);
    check("w4_hold_not_busy", bc, 0);
    @(negedge clk);
    s4 = 4'hA; clr4 = 1'b1;
    @(negedge clk);
    clr4 = 1'b0;
    @(negedge clk);
    check("w4_load_ignored_hold", {23'd0, x4, a4, b4}, 32'h0F);
    run4 = 1'b0;
    @(negedge clk);

    // Reset in the fifth ADD cycle aborts everything asynchronously.
    load_b(8'h5A);
    @(negedge clk);
    sm = 1'b1; s = 8'h33; run = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {13'd0, aval, bval, x, busy, done}, 32'd0);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      #1;
      check("post_reset_idle", {30'd0, busy, done}, 32'd0);
    end

    // Run rise together with load: load wins, no operation starts.
    @(negedge clk);
    s = 8'h3C; run = 1'b1; clr_ld = 1'b1;
    @(negedge clk);
    clr_ld = 1'b0;
    bc = 0;
    for (int j = 0; j < 5; j++) begin
      @(posedge clk);
      #1;
      if (busy) bc++;
    end
    check("priority_busy", bc, 0);
    check("priority_loaded", {23'd0, x, aval, bval}, 32'h003C);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_param.md
SEQ_MULT_PARAM -- requirements
Module: seq_mult_param

Interface
REQ-001 The block SHALL take parameter WIDTH, default 8: operand width in bits; legal range 2..32.
REQ-002 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port Reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port Run, input, 1 bit: synchronous, active-high; a rising edge starts a multiply.
REQ-005 The block SHALL have port ClearA_LoadB, input, 1 bit: synchronous, active-high; clears X and A, and loads B from S.
REQ-006 The block SHALL have port Signed_Mode, input, 1 bit: 1 selects two's-complement, 0 selects unsigned; sampled at start.
REQ-007 The block SHALL have port S, input, WIDTH bits: multiplicand during Run; load value for B on ClearA_LoadB.
REQ-008 The block SHALL have port Aval, output, WIDTH bits: register A, the upper product half.
REQ-009 The block SHALL have port Bval, output, WIDTH bits: register B, the multiplier and then the lower product half.
REQ-010 The block SHALL have port X, output, 1 bit: extension bit above A.
REQ-011 The block SHALL have port Busy, output, 1 bit: high in states CLR, ADD and SHIFT.
REQ-012 The block SHALL have port Done, output, 1 bit: one-cycle pulse on completion.

Function
REQ-013 The block SHALL register Run into Run_q each cycle; a rise is Run & ~Run_q.
REQ-014 The FSM SHALL have the states IDLE, CLR, ADD, SHIFT and HOLD, with an iteration counter of $clog2(WIDTH)+1 bits.
REQ-015 In IDLE with ClearA_LoadB=1, the block SHALL set X<=0, A<=0 and B<=S, and SHALL stay in IDLE.
REQ-016 In IDLE with a Run rise and ClearA_LoadB=0, the FSM SHALL go to CLR and latch Signed_Mode into an internal mode bit.
- Simultaneous Run rise and ClearA_LoadB: the load wins and the rise is discarded; a new press is needed.
REQ-017 In CLR, the block SHALL set X<=0, A<=0 and count<=0, and SHALL go to ADD.
- B is kept, so consecutive Runs multiply the previous low half by S.
REQ-018 In ADD with M=B[0]=1, the block SHALL form a (WIDTH+1)-bit sum of ext(A) and ext(S).
- ext is sign extension in signed mode and zero extension in unsigned mode.
- In signed mode with count=WIDTH-1, S SHALL be subtracted (ext(A) + ~ext(S) + 1).
- The results SHALL be A<=sum[WIDTH-1:0] and X<=sum[WIDTH].
REQ-019 In ADD with M=0, X, A and B SHALL be unchanged; the cycle is still spent, giving fixed latency.
REQ-020 In SHIFT, the block SHALL shift {X,A,B} right by one.
- The new X SHALL be the old X in signed mode (arithmetic shift) and 0 in unsigned mode.
- count SHALL increment.
- The next state SHALL be ADD if the new count < WIDTH, else HOLD.
REQ-021 On entry to HOLD, Done SHALL be 1 for exactly one cycle; HOLD SHALL stay while Run=1 and go to IDLE when Run=0.
REQ-022 Latency: Done SHALL assert exactly 2*WIDTH+1 rising edges after the edge that moves IDLE to CLR.
REQ-023 Result: {A,B} SHALL be the 2*WIDTH-bit product, two's-complement in signed mode; X SHALL equal the product sign in signed mode and 0 in unsigned mode.
REQ-024 ClearA_LoadB SHALL be ignored in CLR, ADD, SHIFT and HOLD; a Run rise outside IDLE SHALL be ignored.
REQ-025 S SHALL be held stable by the user from the Run rise to Done; the block does not capture it.
REQ-026 Overflow cannot occur: the (WIDTH+1)-bit sum SHALL hold every intermediate value, including -2^(WIDTH-1) * -2^(WIDTH-1).

Reset
REQ-027 Reset=0 SHALL immediately set the FSM to IDLE and clear X, A, B, count, mode, Run_q, Busy and Done to 0.
REQ-028 Reset asserted mid-operation SHALL abort the operation with no partial result kept; after release the block SHALL wait for a fresh Run rise.
REQ-029 Outputs SHALL hold their reset values until the first rising edge after release.

Verification (WIDTH=8 unless stated)
REQ-030 Signed multiply: load B=0x07, Signed_Mode=1, S=0xFE, Run -> Done pulse; A=0xFF, B=0xF2, X=1 (-14).
REQ-031 Chained run: after REQ-030, release Run and press again with S=0xFE -> A=0x00, B=0x1C, X=0 (28).
REQ-032 Corner case: signed, B=0x80, S=0x80 -> A=0x40, B=0x00, X=0; unsigned, B=0xFF, S=0xFF -> A=0xFE, B=0x01, X=0.
REQ-033 Latency and hold, WIDTH=4:
- Done SHALL be high exactly 9 edges after CLR entry, and Busy high for those 9 cycles.
- With Run held 20 more cycles, state SHALL stay HOLD with no second Done.
- ClearA_LoadB pulsed during HOLD SHALL leave A and B unchanged.
REQ-034 Reset and priority:
- Assert Reset on the 5th ADD cycle -> all outputs 0 asynchronously and IDLE.
- Run and ClearA_LoadB rising together in IDLE -> B=S loaded and Busy stays 0.
